pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).
- Detects load-use hazards and freezes the front end for one cycle.
- Sequences multi-cycle multiply occupancy of EX.
- Squashes wrong-path instructions when a branch resolves taken in MEM.
- Keeps saturating stall/flush performance counters readable by the test bench.

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for a 5-stage pipeline (load-use, multiply, taken branch).
// Latency: control outputs are combinational (Mealy) from state and inputs; counters update on clk_i.
// Backpressure: holds the front end via pc/ifid/idex write enables; taken branch overrides any stall.
module pipe_hazard_ctrl #(
  parameter int MUL_STALL = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mul_i,
  input  logic             mem_br_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             mul_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [7:0]       flush_cnt_o
);

  typedef enum logic [0:0] {RUN, MUL_WAIT} state_t;

  // First MUL_WAIT countdown value; the start cycle is itself one stall cycle.
  localparam logic [3:0] CNT_INIT = (MUL_STALL >= 2) ? 4'(MUL_STALL - 2) : 4'd0;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             mul_done_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [7:0]       flush_cnt_q;

  logic br_evt;
  logic mul_start;
  logic mul_hold;
  logic load_use;
  logic rs_hit;
  logic rt_hit;

  // Hazard classification in priority order: branch, multiply, load-use.
  always_comb begin
    br_evt    = mem_br_taken_i;
    mul_start = (state_q == RUN) && ex_mul_i && !mul_done_q && !br_evt;
    mul_hold  = (state_q == MUL_WAIT) && !br_evt;
    rs_hit    = (ex_rd_i == id_rs_i);
    rt_hit    = id_uses_rt_i && (ex_rd_i == id_rt_i);
    // A multiply in EX (even one that is finishing) masks an illegal concurrent load flag.
    load_use  = (state_q == RUN) && !br_evt && !ex_mul_i && ex_memread_i &&
                (ex_rd_i != 5'd0) && (rs_hit || rt_hit);
  end

  // Mealy control outputs; everything is held low while reset is asserted.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    idex_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    mul_busy_o    = (state_q == MUL_WAIT);
    if (br_evt) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end else if (mul_start || mul_hold) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      exmem_flush_o = 1'b1;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_flush_o  = 1'b1;
    end
    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_flush_o  = 1'b0;
      exmem_flush_o = 1'b0;
      mul_busy_o    = 1'b0;
    end
  end

  // Multiply occupancy FSM; mul_done_q keeps a finished multiply from re-triggering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      cnt_q      <= 4'd0;
      mul_done_q <= 1'b0;
    end else if (br_evt) begin
      state_q    <= RUN;
      cnt_q      <= 4'd0;
      mul_done_q <= 1'b0;
    end else if (state_q == MUL_WAIT) begin
      if (cnt_q == 4'd0) begin
        state_q    <= RUN;
        mul_done_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end else if (mul_start) begin
      if (MUL_STALL == 1) begin
        mul_done_q <= 1'b1;
      end else begin
        state_q <= MUL_WAIT;
        cnt_q   <= CNT_INIT;
      end
    end else begin
      mul_done_q <= 1'b0;
    end
  end

  // Saturating performance counters for stalled cycles and taken-branch flushes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= 8'd0;
    end else begin
      if (!pc_write_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (br_evt && (flush_cnt_q != 8'hFF)) begin
        flush_cnt_q <= flush_cnt_q + 8'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic against a reference model.
// The model tracks remaining multiply stall cycles as a plain integer and saturating counters as ints.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_pipe_hazard_ctrl;

  localparam int MS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs = 5'd0;
  logic [4:0]  id_rt = 5'd0;
  logic        id_uses_rt = 1'b0;
  logic        ex_memread = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic        ex_mul = 1'b0;
  logic        br = 1'b0;
  logic        pc_write, ifid_write, idex_write;
  logic        ifid_flush, idex_flush, exmem_flush, mul_busy;
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_rem   = 0;   // stall cycles still owed by the multiply occupying EX
  bit m_done  = 0;   // the multiply currently in EX has already served its stalls
  int m_stall = 0;
  int m_flush = 0;

  pipe_hazard_ctrl #(.MUL_STALL(MS), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rd_i(ex_rd), .ex_mul_i(ex_mul),
    .mem_br_taken_i(br),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .idex_write_o(idex_write),
    .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush), .exmem_flush_o(exmem_flush),
    .mul_busy_o(mul_busy), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, compare at negedge, advance model and clock.
  task automatic cycle(input logic b, input logic mul, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input bit check, input string tag);
    bit e_pc, e_ifid, e_idex, e_f1, e_f2, e_f3, e_busy;
    br = b; ex_mul = mul; ex_memread = mr; ex_rd = rd;
    id_rs = rs; id_rt = rt; id_uses_rt = urt;
    e_pc = 1; e_ifid = 1; e_idex = 1; e_f1 = 0; e_f2 = 0; e_f3 = 0;
    e_busy = (m_rem > 0);
    if (b) begin
      e_f1 = 1; e_f2 = 1; e_f3 = 1;
      m_rem = 0; m_done = 0;
    end else if (m_rem > 0) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_f3 = 1;
      m_rem--;
      if (m_rem == 0) m_done = 1;
    end else if (mul && !m_done) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_f3 = 1;
      m_rem = MS - 1;
      m_done = (m_rem == 0);
    end else begin
      m_done = 0;
      if (mr && !mul && rd != 0 && (rd == rs || (urt && rd == rt))) begin
        e_pc = 0; e_ifid = 0; e_f2 = 1;
      end
    end
    @(negedge clk);
    if (check) begin
      chk({tag, ".pc"}, 32'(pc_write), 32'(e_pc));
      chk({tag, ".ifid_we"}, 32'(ifid_write), 32'(e_ifid));
      chk({tag, ".idex_we"}, 32'(idex_write), 32'(e_idex));
      chk({tag, ".ifid_fl"}, 32'(ifid_flush), 32'(e_f1));
      chk({tag, ".idex_fl"}, 32'(idex_flush), 32'(e_f2));
      chk({tag, ".exmem_fl"}, 32'(exmem_flush), 32'(e_f3));
      chk({tag, ".busy"}, 32'(mul_busy), 32'(e_busy));
      chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
      chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
    end
    if (!e_pc && m_stall < 65535) m_stall++;
    if (b && m_flush < 255) m_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, tag);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".pc"}, 32'(pc_write), 0);
    chk({tag, ".ifid_we"}, 32'(ifid_write), 0);
    chk({tag, ".idex_we"}, 32'(idex_write), 0);
    chk({tag, ".flushes"}, 32'({ifid_flush, idex_flush, exmem_flush}), 0);
    chk({tag, ".busy"}, 32'(mul_busy), 0);
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 0);
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 0);
  endtask

  initial begin
    // Reset held: everything low
    br = 1'b1;
    ex_mul = 1'b1;
    #12;
    chk_reset_outs("rst");
    br = 1'b0;
    ex_mul = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset
    idle(5, "idle");

    // Load-use on rs, then clean follow-up with bubble in EX
    cycle(0, 0, 1, 5'd2, 5'd2, 5'd7, 0, 1, "lu_rs");
    cycle(0, 0, 0, 5'd0, 5'd2, 5'd7, 0, 1, "lu_after");
    chk("lu_cnt", 32'(stall_cnt), 1);
    // rd=0 never stalls; rt match only counts when rt is used
    cycle(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, "lu_r0");
    cycle(0, 0, 1, 5'd9, 5'd1, 5'd9, 0, 1, "lu_rt_unused");
    cycle(0, 0, 1, 5'd9, 5'd1, 5'd9, 1, 1, "lu_rt");
    idle(1, "idle2");

    // Single multiply held in EX: MS stall cycles then one clean cycle
    for (int i = 0; i < MS + 1; i++) cycle(0, 1, 0, 5'd3, 5'd3, 5'd3, 1, 1, "mul1");
    idle(1, "idle3");
    // Back-to-back multiplies
    for (int i = 0; i < 2 * (MS + 1); i++) cycle(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, "mul2");
    idle(1, "idle4");

    // Branch on the multiply-start cycle aborts the multiply
    cycle(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, "br_mul");
    cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, "br_mul_after");
    // Branch in the middle of MUL_WAIT
    cycle(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, "mul3");
    cycle(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, "br_wait");
    idle(1, "idle5");
    // Branch together with a load-use hazard
    cycle(1, 0, 1, 5'd4, 5'd4, 5'd0, 0, 1, "br_lu");
    idle(1, "idle6");

    // Asynchronous reset while in MUL_WAIT
    cycle(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, "mul4");
    chk("mul4_busy", 32'(mul_busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outs("arst");
    m_rem = 0; m_done = 0; m_stall = 0; m_flush = 0;
    ex_mul = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle(3, "post_arst");

    // Random traffic from small register ranges to hit hazards often
    for (int i = 0; i < 400; i++) begin
      logic rb, rm, rmr;
      rb  = ($urandom_range(0, 15) == 0);
      rm  = ($urandom_range(0, 5) == 0);
      rmr = rm ? 1'b0 : 1'($urandom_range(0, 1));
      cycle(rb, rm, rmr, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1, "rand");
    end

    // Flush counter saturation
    for (int i = 0; i < 260; i++) cycle(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "br_sat");
    chk("flush_sat", 32'(flush_cnt), 255);
    cycle(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, "br_sat_chk");

    // Stall counter saturation with a held load-use hazard
    for (int i = 0; i < 65540; i++) cycle(0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, "st_sat");
    chk("stall_sat", 32'(stall_cnt), 65535);
    cycle(0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, "st_sat_chk");
    chk("stall_hold", 32'(stall_cnt), 65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
